// File: rtl/write_on_exec_pkg.sv
// Shared types and the operation helper for the write-on-exec dataflow node.
package write_on_exec_pkg;

    localparam int unsigned MAX_IN = 4;
    // Widest operand the shared helper handles; callers zero-extend and truncate.
    localparam int unsigned MAX_W  = 32;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_MIN   = 3'd5,
        OP_MAX   = 3'd6,
        OP_PASS0 = 3'd7
    } op_e;

    // One step of the left fold; also used by the accumulator (acc OP result).
    // Arithmetic wraps; callers keep only the low DATA_W bits.
    function automatic logic [MAX_W-1:0] apply_op(
        input op_e              op,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b
    );
        logic [MAX_W-1:0] r;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_MIN:   r = (a < b) ? a : b;
            OP_MAX:   r = (a > b) ? a : b;
            OP_PASS0: r = a;
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/write_on_exec_node_sync_fifo.sv
// Small synchronous FIFO with a combinational head; one per input channel.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Pushes while full and pops while empty are dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rdata   = mem[rptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + AW'(1);
            if (do_pop)
                rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/write_on_exec_node.sv
// CGRA dataflow node: buffers NUM_IN operand streams, fires when all heads are
// present and the output slot is free, and registers the folded result.
module write_on_exec_node
    import write_on_exec_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_IN     = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               cfg_op,
    input  logic                     cfg_acc_en,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         exec_count
);

    logic [DATA_W-1:0] head [NUM_IN];
    logic [NUM_IN-1:0] empty;
    logic [NUM_IN-1:0] full;
    logic              fire;
    op_e               op;
    logic [DATA_W-1:0] fold;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        sync_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (in_valid[i]),
            .pop   (fire),
            .wdata (in_data[i*DATA_W +: DATA_W]),
            .rdata (head[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    // Ready depends only on registered FIFO occupancy, never on out_ready.
    assign in_ready = ~full;
    assign fire     = (&(~empty)) && (!out_valid || out_ready);
    assign op       = op_e'(cfg_op);

    // Left fold of the channel heads, then optional accumulation into acc.
    always_comb begin
        fold = head[0];
        for (int unsigned i = 1; i < NUM_IN; i++)
            fold = DATA_W'(apply_op(op, MAX_W'(fold), MAX_W'(head[i])));
        acc_next = cfg_acc_en ? DATA_W'(apply_op(op, MAX_W'(acc), MAX_W'(fold)))
                              : fold;
    end

    // Output register, accumulator and firing counter; written only on fire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            exec_count <= '0;
        end else if (fire) begin
            acc        <= acc_next;
            out_data   <= acc_next;
            out_valid  <= 1'b1;
            exec_count <= exec_count + CNT_W'(1);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_write_on_exec_node.sv
// Scoreboard bench for write_on_exec_node: a 2-input and a 4-input instance.
module tb_write_on_exec_node;
    import write_on_exec_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [2:0]  op2;
    logic        acc2;
    logic [15:0] d2;
    logic [1:0]  v2, r2;
    logic [7:0]  o2;
    logic        ov2, ordy2;
    logic [15:0] c2;

    logic [2:0]  op4;
    logic        acc4;
    logic [31:0] d4;
    logic [3:0]  v4, r4;
    logic [7:0]  o4;
    logic        ov4, ordy4;
    logic [15:0] c4;

    write_on_exec_node #(.DATA_W(8), .NUM_IN(2), .FIFO_DEPTH(4), .CNT_W(16)) u2 (
        .clk(clk), .reset(reset), .cfg_op(op2), .cfg_acc_en(acc2),
        .in_data(d2), .in_valid(v2), .in_ready(r2),
        .out_data(o2), .out_valid(ov2), .out_ready(ordy2), .exec_count(c2)
    );

    write_on_exec_node #(.DATA_W(8), .NUM_IN(4), .FIFO_DEPTH(4), .CNT_W(16)) u4 (
        .clk(clk), .reset(reset), .cfg_op(op4), .cfg_acc_en(acc4),
        .in_data(d4), .in_valid(v4), .in_ready(r4),
        .out_data(o4), .out_valid(ov4), .out_ready(ordy4), .exec_count(c4)
    );

    typedef struct {
        logic [7:0]  data;
        logic [15:0] cnt;
    } exp_t;

    exp_t q2[$];
    exp_t q4[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 2-input node: each accepted result is matched in order.
    always @(negedge clk) begin
        if (reset && ov2 && ordy2) begin
            if (q2.size() == 0) begin
                chk("out2_unexpected", 32'(o2), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("out2_data", 32'(o2), 32'(e.data));
                chk("out2_cnt", 32'(c2), 32'(e.cnt));
            end
        end
    end

    // Monitor for the 4-input node.
    always @(negedge clk) begin
        if (reset && ov4 && ordy4) begin
            if (q4.size() == 0) begin
                chk("out4_unexpected", 32'(o4), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("out4_data", 32'(o4), 32'(e.data));
                chk("out4_cnt", 32'(c4), 32'(e.cnt));
            end
        end
    end

    task automatic push2(input logic [7:0] a, input logic [7:0] b, input logic [1:0] mask);
        int n = 0;
        while (((r2 & mask) != mask) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("push2_ready_timeout", 32'(r2 & mask), 32'(mask));
        d2 = {b, a};
        v2 = mask;
        tick();
        v2 = '0;
    endtask

    task automatic push4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        int n = 0;
        while (r4 != 4'hF && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("push4_ready_timeout", 32'(r4), 32'hF);
        d4 = {d, c, b, a};
        v4 = 4'hF;
        tick();
        v4 = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q2.size() != 0 || q4.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'(q2.size() + q4.size()), 32'd0);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(ov2), 32'd0);
        chk("rst_cnt", 32'(c2), 32'd0);
        chk("rst_data", 32'(o2), 32'd0);
        q2.delete();
        q4.delete();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_ready2", 32'(r2), 32'h3);
        chk("rst_ready4", 32'(r4), 32'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        op2 = OP_ADD; acc2 = 1'b0; d2 = '0; v2 = '0; ordy2 = 1'b1;
        op4 = OP_MAX; acc4 = 1'b0; d4 = '0; v4 = '0; ordy4 = 1'b1;
        #12;
        chk("init_valid", 32'(ov2), 32'd0);
        chk("init_data", 32'(o2), 32'd0);
        chk("init_cnt", 32'(c2), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("init_ready", 32'(r2), 32'h3);

        // 1: ADD 5+7, two-edge latency
        q2.push_back('{8'd12, 16'd1});
        push2(8'd5, 8'd7, 2'b11);
        @(negedge clk);
        chk("lat_before", 32'(ov2), 32'd0);
        @(negedge clk);
        chk("lat_after", 32'(ov2), 32'd1);
        wait_drain();

        // 2: skewed arrival, SUB 3-5 wraps to FE
        op2 = OP_SUB;
        push2(8'd3, 8'd0, 2'b01);
        for (int k = 0; k < 3; k++) begin
            chk("skew_nofire", 32'(ov2), 32'd0);
            tick();
        end
        chk("skew_cnt", 32'(c2), 32'd1);
        q2.push_back('{8'hFE, 16'd2});
        push2(8'd0, 8'd5, 2'b10);
        wait_drain();

        // 3: backpressure, FIFOs fill, then stream out one per cycle
        op2 = OP_ADD;
        ordy2 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            q2.push_back('{8'(11 * k), 16'(2 + k)});
            push2(8'(10 * k), 8'(k), 2'b11);
        end
        chk("full_ready", 32'(r2), 32'd0);
        chk("held_valid", 32'(ov2), 32'd1);
        chk("held_data", 32'(o2), 32'd11);
        chk("held_cnt", 32'(c2), 32'd3);
        ordy2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stream_valid", 32'(ov2), 32'd1);
        end
        @(negedge clk);
        chk("stream_end", 32'(ov2), 32'd0);
        chk("stream_cnt", 32'(c2), 32'd7);
        #6;
        wait_drain();

        // 4: accumulate ADD, then plain fire
        do_reset();
        op2 = OP_ADD;
        acc2 = 1'b1;
        q2.push_back('{8'd2, 16'd1});
        q2.push_back('{8'd6, 16'd2});
        q2.push_back('{8'd12, 16'd3});
        push2(8'd1, 8'd1, 2'b11);
        push2(8'd2, 8'd2, 2'b11);
        push2(8'd3, 8'd3, 2'b11);
        wait_drain();
        acc2 = 1'b0;
        q2.push_back('{8'd8, 16'd4});
        push2(8'd4, 8'd4, 2'b11);
        wait_drain();

        // 5: four-input MAX, PASS0 pops every channel, MAX again
        op4 = OP_MAX;
        q4.push_back('{8'd200, 16'd1});
        push4(8'd9, 8'd200, 8'd17, 8'd3);
        wait_drain();
        op4 = OP_PASS0;
        q4.push_back('{8'd9, 16'd2});
        push4(8'd9, 8'd200, 8'd17, 8'd3);
        wait_drain();
        chk("pass0_ready", 32'(r4), 32'hF);
        op4 = OP_MAX;
        q4.push_back('{8'd4, 16'd3});
        push4(8'd1, 8'd2, 8'd3, 8'd4);
        wait_drain();

        // 6: reset mid-stream with held output and partly filled FIFOs
        op2 = OP_ADD;
        ordy2 = 1'b0;
        q2.push_back('{8'd3, 16'd1});
        push2(8'd1, 8'd2, 2'b11);
        push2(8'd3, 8'd4, 2'b11);
        push2(8'd5, 8'd6, 2'b11);
        chk("mid_valid", 32'(ov2), 32'd1);
        do_reset();
        ordy2 = 1'b1;
        q2.push_back('{8'd127, 16'd1});
        push2(8'd100, 8'd27, 2'b11);
        wait_drain();

        chk("q2_empty", 32'(q2.size()), 32'd0);
        chk("q4_empty", 32'(q4.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/write_on_exec_node.md
Name: write_on_exec_node

Overview:
- Parametrised CGRA dataflow node and successor to SimpleWriteOnExec.
- Buffers operands from NUM_IN independent input channels and fires one operation when every channel holds an operand.
- Writes the result to a registered output only on execution ("write-on-exec"), optionally accumulating across firings.
- Sits between routing switches in the CGRA fabric; all edges use valid/ready handshakes.

Parameters:
- DATA_W, 8, operand/result width in bits
- NUM_IN, 2, number of input channels (2..4)
- FIFO_DEPTH, 4, entries per input FIFO (power of 2, >=2)
- CNT_W, 16, width of execution counter

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cfg_op  input  3  operation select (op_e)
- cfg_acc_en  input  1  accumulate mode enable
- in_data  input  NUM_IN*DATA_W  packed operands, channel i at [i*DATA_W +: DATA_W]
- in_valid  input  NUM_IN  per-channel valid
- in_ready  output  NUM_IN  per-channel ready
- out_data  output  DATA_W  result
- out_valid  output  1  result valid
- out_ready  input  1  downstream ready
- exec_count  output  CNT_W  number of firings since reset

Behaviour:
- Reset (reset low, async): all FIFOs empty; out_valid=0; out_data=0; accumulator=0; exec_count=0; in_ready=all 1 once reset deasserts.
- Input handshake:
  - Channel i pushes when in_valid[i] && in_ready[i].
  - in_ready[i] = !full[i], computed from registered count.
  - No combinational path from out_ready to in_ready.
- Fire condition: all FIFOs non-empty && (!out_valid || out_ready).
- On fire:
  - Pop every FIFO head in the same cycle.
  - Register the result into out_data.
  - Set out_valid=1.
  - exec_count += 1, wrapping mod 2^CNT_W.
- No fire: out_data holds its value. out_valid clears only on out_valid && out_ready without a simultaneous fire.
- Back-to-back fire with out_ready=1 keeps out_valid=1 and sustains one result per cycle.
- Latency: operand accepted at edge t -> result valid after edge t+1 (2-cycle minimum). The latency is fixed whenever no stall occurs.
- Operation, left fold over channels 0..NUM_IN-1, all arithmetic modulo 2^DATA_W, unsigned:
  - ADD=0, SUB=1 (ch0 - ch1 - ...), AND=2, OR=3, XOR=4, MIN=5, MAX=6, PASS0=7 (ch0 only; other heads still popped).
- Accumulate mode (cfg_acc_en=1): acc <= acc OP result; out_data <= the new acc. When cfg_acc_en=0, acc is loaded with result on each fire so that a later enable starts from the last result.
- Config: cfg_op and cfg_acc_en are sampled at the fire cycle only. Changes between fires take effect on the next fire; no flush is performed.
- Boundary conditions:
  - FIFO full: in_ready[i]=0. A push attempted while full is ignored and the data is lost; the bench flags it as a protocol error.
  - Push and pop on the same channel in the same cycle: count is unchanged, and both occur.
  - FIFO pointers wrap mod FIFO_DEPTH.
  - Output stalled (out_valid && !out_ready): no fire; inputs keep filling until full.
  - Reset asserted mid-operation: immediate clear of all state as above. In-flight data is discarded.

Decomposition:
- Package write_on_exec_pkg:
  - op_e enum (3-bit, values above)
  - function apply_op(op_e, a, b) shared by fold and accumulator
  - localparam MAX_IN=4
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports clk, reset, push, pop, wdata, rdata (head, combinational), empty, full.
  - Instantiated NUM_IN times via generate.

Test Plan:
1. Reset, NUM_IN=2, ADD: push ch0=5 and ch1=7 in the same cycle -> out_data=12, out_valid=1 two edges later, exec_count=1.
2. Skewed arrival, SUB: ch0=3 at t0, ch1=5 at t3 -> a single fire after t3 gives out_data=0xFE (wrap); no fire before t3.
3. Backpressure: out_ready=0, push 5 pairs with FIFO_DEPTH=4 -> one result held, FIFOs fill, in_ready=0 after 4+1 accepted pairs. Raise out_ready -> 5 results in order, one per cycle.
4. Accumulate ADD, cfg_acc_en=1: pairs (1,1),(2,2),(3,3) -> out_data sequence 2, 6, 12. Clearing cfg_acc_en then pair (4,4) -> out_data=8.
5. NUM_IN=4, MAX: operands (9,200,17,3) -> out_data=200. PASS0 with (9,200,17,3) -> 9, and all four FIFOs are popped.
6. Reset mid-stream: assert reset low with FIFOs half full and out_valid=1 -> out_valid=0, exec_count=0, out_data=0 immediately (async). After release, the first new pair produces a correct result.
